jtagg_user_reg: RTL

Parametrised successor of the single-channel JTAGG TDI capture path. Oversamples the raw JTAGG user-port signals in the system clock domain and implements 1–2 independent JTAG user data registers (ER1/JCE1, ER2/JCE2). Each register has shift-in, update-commit with a valid pulse, bit counting and a TDO response path. Sits between the JTAGG primitive and user logic (hex display, debug registers); it replaces the spi_slave-based capture.

---
 rtl/jtagg_user_reg.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/jtagg_user_reg.sv
// JTAGG user data registers (ER1/ER2) oversampled in the system clock domain.
// Optional capture of rd_data into the TDO path: define JTAGG_USER_REG_READBACK_EN.
module jtagg_user_reg #(
  parameter int C_channels    = 2,
  parameter int C_data_len    = 64,
  parameter int C_count_bits  = 16,
  parameter int C_sync_stages = 2
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               jtck,
  input  logic                               jtdi,
  input  logic                               jshift,
  input  logic                               jupdate,
  input  logic                               jrstn,
  input  logic [C_channels-1:0]              jce,
  output logic [C_channels-1:0]              jtdo,
  input  logic [C_channels*C_data_len-1:0]   rd_data,
  output logic [C_channels*C_data_len-1:0]   data,
  output logic [C_channels-1:0]              valid,
  output logic [C_channels*C_count_bits-1:0] bit_count
);

  localparam int SW = 5 + C_channels;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_EXIT
  } state_e;

  logic [SW-1:0] raw_in;
  logic [SW-1:0] sync_q [C_sync_stages];

  logic                  jtck_s, jtdi_s, jshift_s, jupdate_s, jrstn_s;
  logic [C_channels-1:0] jce_s;
  logic                  jtck_d, jupdate_d;
  logic                  jtck_rise, jtck_fall, jupdate_rise;

  assign raw_in = {jce, jrstn, jupdate, jshift, jtdi, jtck};

  // NOTE: the synchroniser array is small and holds control state, so every
  // stage is reset; large data memories would normally be left unreset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < C_sync_stages; i++) sync_q[i] <= '0;
      jtck_d    <= 1'b0;
      jupdate_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep each stage reading the previous
      // stage's old value, which is what makes this a shift chain.
      sync_q[0] <= raw_in;
      for (int i = 1; i < C_sync_stages; i++) sync_q[i] <= sync_q[i-1];
      jtck_d    <= jtck_s;
      jupdate_d <= jupdate_s;
    end
  end

  // jrstn_s resets low, so the TAP looks held in reset until the chain fills.
  assign jtck_s    = sync_q[C_sync_stages-1][0];
  assign jtdi_s    = sync_q[C_sync_stages-1][1];
  assign jshift_s  = sync_q[C_sync_stages-1][2];
  assign jupdate_s = sync_q[C_sync_stages-1][3];
  assign jrstn_s   = sync_q[C_sync_stages-1][4];
  assign jce_s     = sync_q[C_sync_stages-1][SW-1:5];

  assign jtck_rise    = jtck_s & ~jtck_d;
  assign jtck_fall    = ~jtck_s & jtck_d;
  assign jupdate_rise = jupdate_s & ~jupdate_d;

`ifndef JTAGG_USER_REG_READBACK_EN
  logic unused_rd;
  assign unused_rd = ^rd_data;
`endif

  for (genvar k = 0; k < C_channels; k++) begin : g_ch
    state_e                  state;
    logic [C_data_len-1:0]   work;
    logic [C_data_len-1:0]   shadow;
    logic [C_data_len-1:0]   data_q;
    logic [C_data_len-1:0]   load_word;
    logic [C_count_bits-1:0] cnt;
    logic [C_count_bits-1:0] count_q;
    logic                    valid_q;
    logic                    tdo_q;
    logic                    sel;

    assign sel = jshift_s & jce_s[k];

`ifdef JTAGG_USER_REG_READBACK_EN
    assign load_word = rd_data[k*C_data_len +: C_data_len];
`else
    assign load_word = data_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state   <= S_IDLE;
        work    <= '0;
        shadow  <= '0;
        data_q  <= '0;
        cnt     <= '0;
        count_q <= '0;
        valid_q <= 1'b0;
        tdo_q   <= 1'b0;
      end else begin
        valid_q <= 1'b0;
        if (!jrstn_s) begin
          // TAP reset abandons the transaction; committed outputs are kept.
          state <= S_IDLE;
          tdo_q <= 1'b0;
        end else begin
          case (state)
            S_IDLE: begin
              tdo_q <= 1'b0;
              if (sel) begin
                state  <= S_SHIFT;
                cnt    <= '0;
                shadow <= load_word;
                work   <= load_word;
              end
            end
            S_SHIFT: begin
              if (!jshift_s) begin
                state <= S_EXIT;
                tdo_q <= 1'b0;
              end else begin
                if (jtck_rise && sel) begin
                  work   <= {jtdi_s, work[C_data_len-1:1]};
                  shadow <= {1'b0, shadow[C_data_len-1:1]};
                  if (cnt != '1) cnt <= cnt + C_count_bits'(1);
                end
                if (jtck_fall) tdo_q <= shadow[0];
              end
            end
            S_EXIT: begin
              // Pause-DR -> Exit2 -> Shift-DR resumes without losing the count.
              if (sel) begin
                state <= S_SHIFT;
              end else if (jupdate_rise) begin
                data_q  <= work;
                count_q <= cnt;
                valid_q <= 1'b1;
                state   <= S_IDLE;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end

    assign data[k*C_data_len +: C_data_len]       = data_q;
    assign bit_count[k*C_count_bits +: C_count_bits] = count_q;
    assign valid[k] = valid_q;
    assign jtdo[k]  = tdo_q;
  end

endmodule
